// File: rtl/mp_g_aetcam_array_if.sv
// Bus bundle for the multi-port ternary CAM array: write ports, flush, search requests and results.
// The master drives writes and searches; the slave (the array) returns per-port results.
interface mp_g_aetcam_array_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NWP   = 3,
  parameter int NSP   = 3
);
  localparam int IDXW = $clog2(DEPTH);

  logic                  flush;
  logic [NWP-1:0]        wen;
  logic [NWP*IDXW-1:0]   waddr;
  logic [NWP*WIDTH-1:0]  wdata;
  logic [NWP*WIDTH-1:0]  wmask;
  logic [NWP-1:0]        wvalid;
  logic [NSP-1:0]        s_req;
  logic [NSP*WIDTH-1:0]  s_key;
  logic [NSP-1:0]        r_vld;
  logic [NSP-1:0]        r_hit;
  logic [NSP*IDXW-1:0]   r_idx;
  logic [NSP-1:0]        r_multi;

  modport master (
    output flush, wen, waddr, wdata, wmask, wvalid, s_req, s_key,
    input  r_vld, r_hit, r_idx, r_multi
  );

  modport slave (
    input  flush, wen, waddr, wdata, wmask, wvalid, s_req, s_key,
    output r_vld, r_hit, r_idx, r_multi
  );
endinterface

// File: rtl/mp_g_aetcam_array.sv
// Flip-flop ternary CAM: NWP fixed-priority write ports, NSP independent searches
// through a 2-stage pipeline (match vector, then priority encode / multi-hit).
module mp_g_aetcam_array #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NWP   = 3,
  parameter int NSP   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mp_g_aetcam_array_if.slave   bus
);
  localparam int IDXW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0] mask_q, mask_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [NSP-1:0][DEPTH-1:0]   s1_vec_q, s1_vec_d;
  logic [NSP-1:0]              s1_req_q, s1_req_d;
  logic [NSP-1:0]              r_vld_q, r_vld_d;
  logic [NSP-1:0]              r_hit_q, r_hit_d;
  logic [NSP-1:0]              r_multi_q, r_multi_d;
  logic [NSP-1:0][IDXW-1:0]    r_idx_q, r_idx_d;

  // Flush first, then writes; scanning ports high-to-low lets the lowest port win a collision.
  // Out-of-range addresses never equal any entry index, so they are dropped.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    valid_d = bus.flush ? '0 : valid_q;
    for (int e = 0; e < DEPTH; e++) begin
      for (int p = NWP - 1; p >= 0; p--) begin
        if (bus.wen[p] && (bus.waddr[p*IDXW +: IDXW] == IDXW'(e))) begin
          state_d[e] = bus.wdata[p*WIDTH +: WIDTH];
          mask_d[e]  = bus.wmask[p*WIDTH +: WIDTH];
          valid_d[e] = bus.wvalid[p];
        end
      end
    end
  end

  always_comb begin
    s1_vec_d = '0;
    s1_req_d = bus.s_req;
    for (int s = 0; s < NSP; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        s1_vec_d[s][e] = valid_q[e] &
          (&((~(bus.s_key[s*WIDTH +: WIDTH] ^ state_q[e])) | mask_q[e]));
      end
    end
  end

  // Result fields only change when a request completes; otherwise they hold.
  always_comb begin
    r_vld_d   = s1_req_q;
    r_hit_d   = r_hit_q;
    r_multi_d = r_multi_q;
    r_idx_d   = r_idx_q;
    for (int s = 0; s < NSP; s++) begin
      if (s1_req_q[s]) begin
        r_hit_d[s]   = 1'b0;
        r_multi_d[s] = 1'b0;
        r_idx_d[s]   = '0;
        for (int e = 0; e < DEPTH; e++) begin
          if (s1_vec_q[s][e]) begin
            if (r_hit_d[s]) begin
              r_multi_d[s] = 1'b1;
            end else begin
              r_idx_d[s] = IDXW'(e);
            end
            r_hit_d[s] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= '0;
      mask_q    <= '0;
      valid_q   <= '0;
      s1_vec_q  <= '0;
      s1_req_q  <= '0;
      r_vld_q   <= '0;
      r_hit_q   <= '0;
      r_multi_q <= '0;
      r_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      valid_q   <= valid_d;
      s1_vec_q  <= s1_vec_d;
      s1_req_q  <= s1_req_d;
      r_vld_q   <= r_vld_d;
      r_hit_q   <= r_hit_d;
      r_multi_q <= r_multi_d;
      r_idx_q   <= r_idx_d;
    end
  end

  assign bus.r_vld   = r_vld_q;
  assign bus.r_hit   = r_hit_q;
  assign bus.r_multi = r_multi_q;
  assign bus.r_idx   = r_idx_q;

endmodule

// File: tb/tb_mp_g_aetcam_array.sv
// Self-checking bench for mp_g_aetcam_array: directed scenarios plus random traffic
// compared against an entry-list reference model with a two-deep result delay line.
module tb_mp_g_aetcam_array;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int NWP   = 3;
  localparam int NSP   = 3;
  localparam int IDXW  = $clog2(DEPTH);

  typedef struct {
    bit req;
    bit hit;
    int idx;
    bit multi;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mp_g_aetcam_array_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NWP(NWP), .NSP(NSP)) bus ();

  mp_g_aetcam_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NWP(NWP), .NSP(NSP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] m_state [DEPTH];
  logic [WIDTH-1:0] m_mask  [DEPTH];
  bit               m_valid [DEPTH];

  res_t exp_now [NSP];
  res_t exp_mid [NSP];
  res_t exp_out [NSP];
  bit   held_hit   [NSP];
  int   held_idx   [NSP];
  bit   held_multi [NSP];

  int compared = 0;
  int failed   = 0;

  // A key hits an entry when every unmasked bit agrees; the first hit gives the index.
  function automatic res_t ref_search(logic [WIDTH-1:0] key);
    res_t r;
    int   count;
    r     = '{default: 0};
    count = 0;
    r.req = 1'b1;
    for (int e = 0; e < DEPTH; e++) begin
      if (m_valid[e] && (((key ^ m_state[e]) & ~m_mask[e]) == '0)) begin
        if (count == 0) r.idx = e;
        count++;
      end
    end
    r.hit   = (count > 0);
    r.multi = (count > 1);
    return r;
  endfunction

  task automatic check(string tag, int s, logic [31:0] obs, logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      failed++;
      $display("[TB] FAIL %s port%0d: observed %0h expected %0h", tag, s, obs, expv);
      $error("[TB] check %s port%0d observed %0h expected %0h", tag, s, obs, expv);
    end
  endtask

  task automatic clear_inputs();
    bus.flush  = 1'b0;
    bus.wen    = '0;
    bus.waddr  = '0;
    bus.wdata  = '0;
    bus.wmask  = '0;
    bus.wvalid = '0;
    bus.s_req  = '0;
    bus.s_key  = '0;
  endtask

  task automatic put_write(int p, int addr, logic [WIDTH-1:0] data, logic [WIDTH-1:0] mask, bit valid);
    bus.wen[p]                  = 1'b1;
    bus.waddr[p*IDXW +: IDXW]   = IDXW'(addr);
    bus.wdata[p*WIDTH +: WIDTH] = data;
    bus.wmask[p*WIDTH +: WIDTH] = mask;
    bus.wvalid[p]               = valid;
  endtask

  task automatic put_search(int s, logic [WIDTH-1:0] key);
    bus.s_req[s]                = 1'b1;
    bus.s_key[s*WIDTH +: WIDTH] = key;
  endtask

  task automatic checkOutput();
    for (int s = 0; s < NSP; s++) begin
      check("r_vld",   s, 32'(bus.r_vld[s]), 32'(exp_out[s].req));
      check("r_hit",   s, 32'(bus.r_hit[s]), 32'(held_hit[s]));
      check("r_idx",   s, 32'(bus.r_idx[s*IDXW +: IDXW]), 32'(held_idx[s]));
      check("r_multi", s, 32'(bus.r_multi[s]), 32'(held_multi[s]));
    end
  endtask

  // Called at a falling edge with inputs set: predict, clock, update model, check, clear.
  task automatic applyStimulus();
    for (int s = 0; s < NSP; s++) begin
      if (bus.s_req[s]) exp_now[s] = ref_search(bus.s_key[s*WIDTH +: WIDTH]);
      else              exp_now[s] = '{default: 0};
    end
    @(posedge clk);
    for (int s = 0; s < NSP; s++) begin
      exp_out[s] = exp_mid[s];
      exp_mid[s] = exp_now[s];
    end
    if (bus.flush) begin
      for (int e = 0; e < DEPTH; e++) m_valid[e] = 1'b0;
    end
    for (int p = NWP - 1; p >= 0; p--) begin
      int a;
      a = int'(bus.waddr[p*IDXW +: IDXW]);
      if (bus.wen[p] && a < DEPTH) begin
        m_state[a] = bus.wdata[p*WIDTH +: WIDTH];
        m_mask[a]  = bus.wmask[p*WIDTH +: WIDTH];
        m_valid[a] = bus.wvalid[p];
      end
    end
    @(negedge clk);
    for (int s = 0; s < NSP; s++) begin
      if (exp_out[s].req) begin
        held_hit[s]   = exp_out[s].hit;
        held_idx[s]   = exp_out[s].idx;
        held_multi[s] = exp_out[s].multi;
      end
    end
    checkOutput();
    clear_inputs();
  endtask

  task automatic expect_res(int s, bit hit, int idx, bit multi);
    check("dir_vld",   s, 32'(bus.r_vld[s]), 32'd1);
    check("dir_hit",   s, 32'(bus.r_hit[s]), 32'(hit));
    check("dir_idx",   s, 32'(bus.r_idx[s*IDXW +: IDXW]), 32'(idx));
    check("dir_multi", s, 32'(bus.r_multi[s]), 32'(multi));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    for (int e = 0; e < DEPTH; e++) begin
      m_state[e] = '0;
      m_mask[e]  = '0;
      m_valid[e] = 1'b0;
    end
    for (int s = 0; s < NSP; s++) begin
      exp_now[s]    = '{default: 0};
      exp_mid[s]    = '{default: 0};
      exp_out[s]    = '{default: 0};
      held_hit[s]   = 1'b0;
      held_idx[s]   = 0;
      held_multi[s] = 1'b0;
    end
    #2;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    #1;
    do_reset();

    // Empty array: every port misses.
    for (int s = 0; s < NSP; s++) put_search(s, 8'h00);
    applyStimulus();
    applyStimulus();
    for (int s = 0; s < NSP; s++) expect_res(s, 1'b0, 0, 1'b0);

    put_write(1, 5, 8'hA0, 8'h0F, 1'b1);
    applyStimulus();
    put_search(0, 8'hA7);
    put_search(1, 8'hB7);
    applyStimulus();
    applyStimulus();
    expect_res(0, 1'b1, 5, 1'b0);
    expect_res(1, 1'b0, 0, 1'b0);

    put_write(0, 3, 8'h5A, 8'hFF, 1'b1);
    put_write(2, 9, 8'hC3, 8'hFF, 1'b1);
    applyStimulus();
    put_search(2, 8'h3C);
    applyStimulus();
    applyStimulus();
    expect_res(2, 1'b1, 3, 1'b1);

    put_write(0, 3, 8'h5A, 8'hFF, 1'b0);
    applyStimulus();
    put_search(2, 8'h3C);
    applyStimulus();
    applyStimulus();
    expect_res(2, 1'b1, 9, 1'b0);

    // Collision on entry 2: port 0 beats port 2; entry 9 retired at the same edge.
    put_write(0, 2, 8'h11, 8'h00, 1'b1);
    put_write(1, 9, 8'hC3, 8'hFF, 1'b0);
    put_write(2, 2, 8'h22, 8'h00, 1'b1);
    applyStimulus();
    put_search(0, 8'h11);
    put_search(1, 8'h22);
    applyStimulus();
    applyStimulus();
    expect_res(0, 1'b1, 2, 1'b0);
    expect_res(1, 1'b0, 0, 1'b0);

    put_write(0, 4, 8'h55, 8'h00, 1'b1);
    put_search(0, 8'h55);
    applyStimulus();
    put_search(0, 8'h55);
    applyStimulus();
    expect_res(0, 1'b0, 0, 1'b0);
    applyStimulus();
    expect_res(0, 1'b1, 4, 1'b0);

    bus.flush = 1'b1;
    applyStimulus();
    for (int s = 0; s < NSP; s++) put_search(s, 8'hA5);
    applyStimulus();
    applyStimulus();
    for (int s = 0; s < NSP; s++) expect_res(s, 1'b0, 0, 1'b0);

    bus.flush = 1'b1;
    put_write(1, 6, 8'h6E, 8'h01, 1'b1);
    applyStimulus();
    put_search(0, 8'h6F);
    put_search(1, 8'hA5);
    put_search(2, 8'h11);
    applyStimulus();
    applyStimulus();
    expect_res(0, 1'b1, 6, 1'b0);
    expect_res(1, 1'b0, 0, 1'b0);
    expect_res(2, 1'b0, 0, 1'b0);

    // Random traffic: keys are usually near stored entries so hits and multi-hits occur.
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.flush = ($urandom_range(0, 31) == 0);
      for (int p = 0; p < NWP; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          logic [WIDTH-1:0] d, m;
          d = WIDTH'($urandom);
          m = WIDTH'($urandom & $urandom & $urandom);
          if ($urandom_range(0, 15) == 0) m = '1;
          put_write(p, int'($urandom_range(0, DEPTH - 1)), d, m, ($urandom_range(0, 7) != 0));
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        logic [WIDTH-1:0] k;
        k = WIDTH'($urandom);
        for (int s = 0; s < NSP; s++) put_search(s, k);
      end else begin
        for (int s = 0; s < NSP; s++) begin
          if ($urandom_range(0, 3) != 0) begin
            logic [WIDTH-1:0] k;
            k = m_state[$urandom_range(0, DEPTH - 1)];
            if ($urandom_range(0, 3) == 0) k = k ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
            put_search(s, k);
          end
        end
      end
      applyStimulus();
    end
    applyStimulus();
    applyStimulus();

    // Reset one cycle after a request: the in-flight results must never appear.
    put_write(0, 1, 8'h00, 8'hFF, 1'b1);
    applyStimulus();
    for (int s = 0; s < NSP; s++) put_search(s, 8'h77);
    applyStimulus();
    do_reset();
    for (int i = 0; i < 3; i++) applyStimulus();
    put_search(0, 8'h77);
    applyStimulus();
    applyStimulus();
    expect_res(0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
